// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the call/return micro-op sequencers:
// injected stack opcodes, default widths and the return-sequencer state type.
package cpu_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_PC_W   = 32;

    localparam logic [15:0] POP_PC_HIGH_OP = 16'b0110_0000_0000_1011;
    localparam logic [15:0] POP_PC_LOW_OP  = 16'b0110_0000_0000_1010;
    localparam logic [15:0] POP_FLAGS_OP   = 16'b0110_0000_0000_1100;
    localparam logic [15:0] NOP_OP         = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StPopFl,
        StPopHi,
        StPopLo,
        StWait,
        StLoad
    } ret_state_e;

    // Number of words popped for one return sequence.
    function automatic logic [1:0] pop_count(input logic is_rti);
        return is_rti ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/ret_fsm_pop_collector.sv
// Return-word collector: counts popped words from the memory stage and steers
// them into the flags and return-PC registers, flagging when all have arrived.
module ret_fsm_pop_collector
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              is_rti,
    input  logic [DATA_W-1:0] pop_data,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        flags,
    output logic              done
);

    logic [1:0]      rx_cnt_q;
    logic [1:0]      target;
    logic [1:0]      slot;
    logic            take;
    logic [PC_W-1:0] pc_q;
    logic [3:0]      flags_q;

    assign target = pop_count(is_rti);
    assign take   = accept && (rx_cnt_q < target);

    // Slot 0 is flags; a plain RET has no flags word, so its first word lands in the PC-high slot.
    assign slot = is_rti ? rx_cnt_q : rx_cnt_q + 2'd1;

    assign done = (rx_cnt_q == target) || (take && (rx_cnt_q + 2'd1 == target));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt_q <= 2'd0;
            pc_q     <= '0;
            flags_q  <= 4'h0;
        end else if (clear) begin
            rx_cnt_q <= 2'd0;
        end else if (take) begin
            rx_cnt_q <= rx_cnt_q + 2'd1;
            case (slot)
                2'd0:    flags_q                 <= pop_data[3:0];
                2'd1:    pc_q[PC_W-1:DATA_W]     <= pop_data;
                default: pc_q[DATA_W-1:0]        <= pop_data;
            endcase
        end
    end

    assign pc    = pc_q;
    assign flags = flags_q;

endmodule

// File: rtl/ret_fsm.sv
// Return sequencer: on RET/RTI injects POP micro-ops, stalls fetch, reassembles the return PC
// and pulses a PC redirect. RET_FSM_RTI_EN enables the flags pop for RTI.
module ret_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ret,
    input  logic              rti,
    input  logic              pop_valid,
    input  logic [DATA_W-1:0] pop_data,
    output logic [15:0]       out,
    output logic              out_valid,
    output logic              stall,
    output logic [PC_W-1:0]   pc,
    output logic              pc_load,
    output logic [3:0]        flags,
    output logic              flags_load
);

    ret_state_e  state_q, state_d;
    logic        is_rti_q, is_rti_d;
    logic        start_rti;
    logic        accept;
    logic        clear;
    logic        done;
    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        stall_q, stall_d;
    logic        pc_load_q;
    logic        flags_load_q;

`ifdef RET_FSM_RTI_EN
    assign start_rti = rti;
`else
    assign start_rti = 1'b0;
`endif

    // Returned words are taken while a sequence is in flight, but not once the redirect is issued.
    assign accept = pop_valid && (state_q != StIdle) && (state_q != StLoad);
    assign clear  = (state_q == StIdle);

    always_comb begin
        state_d  = state_q;
        is_rti_d = is_rti_q;
        unique case (state_q)
            StIdle: begin
                if (start_rti) begin
                    state_d  = StPopFl;
                    is_rti_d = 1'b1;
                end else if (ret || rti) begin
                    state_d  = StPopHi;
                    is_rti_d = 1'b0;
                end
            end
            StPopFl: state_d = StPopHi;
            StPopHi: state_d = StPopLo;
            StPopLo: state_d = StWait;
            StWait:  if (done) state_d = StLoad;
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        out_d       = NOP_OP;
        out_valid_d = 1'b0;
        stall_d     = (state_d != StIdle);
        case (state_d)
            StPopFl: begin
                out_d       = POP_FLAGS_OP;
                out_valid_d = 1'b1;
            end
            StPopHi: begin
                out_d       = POP_PC_HIGH_OP;
                out_valid_d = 1'b1;
            end
            StPopLo: begin
                out_d       = POP_PC_LOW_OP;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            is_rti_q     <= 1'b0;
            out_q        <= NOP_OP;
            out_valid_q  <= 1'b0;
            stall_q      <= 1'b0;
            pc_load_q    <= 1'b0;
            flags_load_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_rti_q     <= is_rti_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            stall_q      <= stall_d;
            pc_load_q    <= (state_d == StLoad);
            flags_load_q <= (state_d == StLoad) && is_rti_q;
        end
    end

    ret_fsm_pop_collector #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_collector (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .accept   (accept),
        .is_rti   (is_rti_q),
        .pop_data (pop_data),
        .pc       (pc),
        .flags    (flags),
        .done     (done)
    );

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign stall      = stall_q;
    assign pc_load    = pc_load_q;
    assign flags_load = flags_load_q;

endmodule

// File: tb/tb_ret_fsm.sv
// Bench for ret_fsm: directed vector table, hand-written corner sequences and randomized
// traffic compared each cycle against a transaction-level model of the return sequence.
module tb_ret_fsm;
    import cpu_pkg::*;

`ifdef RET_FSM_RTI_EN
    localparam bit RtiEn = 1'b1;
`else
    localparam bit RtiEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ret;
    logic        rti;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [15:0] out;
    logic        out_valid;
    logic        stall;
    logic [31:0] pc;
    logic        pc_load;
    logic [3:0]  flags;
    logic        flags_load;

    ret_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .ret        (ret),
        .rti        (rti),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .out        (out),
        .out_valid  (out_valid),
        .stall      (stall),
        .pc         (pc),
        .pc_load    (pc_load),
        .flags      (flags),
        .flags_load (flags_load)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int loads = 0;
    int fl_loads = 0;

    // Transaction-level model: a sequence issues n pops in its first n cycles, then waits until
    // n words have come back; the last word is PC low, the one before it PC high.
    bit          m_busy, m_load, m_rti;
    int          m_k, m_n, m_got;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_load = 0; m_rti = 0;
        m_k = 0; m_n = 0; m_got = 0;
        m_pc = 32'h0; m_flags = 4'h0;
    endtask

    task automatic model_edge(input bit r, input bit ri, input bit pv, input logic [15:0] pd);
        if (m_load) begin
            m_load = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (r || ri) begin
                m_busy = 1;
                m_k    = 1;
                m_rti  = RtiEn && ri;
                m_n    = m_rti ? 3 : 2;
                m_got  = 0;
            end
        end else begin
            if (pv && m_got < m_n) begin
                m_got++;
                if (m_rti && m_got == 1) m_flags = pd[3:0];
                if (m_got == m_n - 1) m_pc[31:16] = pd;
                if (m_got == m_n) m_pc[15:0] = pd;
            end
            if (m_k > m_n && m_got == m_n) m_load = 1;
            m_k++;
        end
    endtask

    function automatic logic [15:0] exp_op();
        if (!m_busy || m_k > m_n) return NOP_OP;
        if (m_k == m_n) return POP_PC_LOW_OP;
        if (m_k == m_n - 1) return POP_PC_HIGH_OP;
        return POP_FLAGS_OP;
    endfunction

    task automatic compare_model();
        chk("out", out, exp_op());
        chk("out_valid", out_valid, m_busy && m_k <= m_n);
        chk("stall", stall, m_busy);
        chk("pc", pc, m_pc);
        chk("pc_load", pc_load, m_load);
        chk("flags", flags, m_flags);
        chk("flags_load", flags_load, m_load && m_rti);
    endtask

    task automatic step(input bit r, input bit ri, input bit pv, input logic [15:0] pd);
        ret = r; rti = ri; pop_valid = pv; pop_data = pd;
        @(posedge clk);
        model_edge(r, ri, pv, pd);
        #1;
        if (pc_load) loads++;
        if (flags_load) fl_loads++;
        compare_model();
        ret = 0; rti = 0; pop_valid = 0; pop_data = 16'h0;
    endtask

    // Asynchronous reset asserted away from the clock edge, held across one edge.
    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        bit          r;
        bit          ri;
        bit          pv;
        logic [15:0] pd;
        logic [15:0] e_out;
        bit          e_valid;
        bit          e_stall;
        logic [31:0] e_pc;
        bit          e_load;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit r, input bit pv, input logic [15:0] pd,
                                input logic [15:0] e_out, input bit e_valid, input bit e_stall,
                                input logic [31:0] e_pc, input bit e_load);
        vec_t v;
        v.r = r; v.ri = 1'b0; v.pv = pv; v.pd = pd;
        v.e_out = e_out; v.e_valid = e_valid; v.e_stall = e_stall;
        v.e_pc = e_pc; v.e_load = e_load;
        return v;
    endfunction

    initial begin
        int          loads_before;
        int          fl_before;
        logic [15:0] words[$];

        reset = 1'b0; ret = 0; rti = 0; pop_valid = 0; pop_data = 16'h0;
        model_reset();

        // Normal RET with data in the first WAIT cycles, then RET with data 4 cycles late.
        vecs.push_back(mk(1, 0, 16'h0000, POP_PC_HIGH_OP, 1, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, POP_PC_LOW_OP,  1, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 16'h0000, NOP_OP,         0, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 1, 16'h0000, NOP_OP,         0, 1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 1, 16'h0F0F, NOP_OP,         0, 1, 32'h0000_0F0F, 1));
        vecs.push_back(mk(0, 0, 16'h0000, NOP_OP,         0, 0, 32'h0000_0F0F, 0));
        vecs.push_back(mk(1, 0, 16'h0000, POP_PC_HIGH_OP, 1, 1, 32'h0000_0F0F, 0));
        vecs.push_back(mk(0, 0, 16'h0000, POP_PC_LOW_OP,  1, 1, 32'h0000_0F0F, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 16'h0000, NOP_OP, 0, 1, 32'h0000_0F0F, 0));
        vecs.push_back(mk(0, 1, 16'hFF00, NOP_OP,         0, 1, 32'hFF00_0F0F, 0));
        vecs.push_back(mk(0, 1, 16'h0F0F, NOP_OP,         0, 1, 32'hFF00_0F0F, 1));
        vecs.push_back(mk(0, 0, 16'h0000, NOP_OP,         0, 0, 32'hFF00_0F0F, 0));
        vecs.push_back(mk(0, 0, 16'h0000, NOP_OP,         0, 0, 32'hFF00_0F0F, 0));

        // Reset held low for two cycles.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out", out, NOP_OP);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_load", pc_load, 1'b0);
        chk("rst_flags", flags, 4'h0);
        chk("rst_flags_load", flags_load, 1'b0);
        reset = 1'b1;

        loads_before = loads;
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].ri, vecs[i].pv, vecs[i].pd);
            chk($sformatf("vec%0d_out", i), out, vecs[i].e_out);
            chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_load", i), pc_load, vecs[i].e_load);
        end
        chk("vec_load_count", loads - loads_before, 2);

        // RET repeated during POP_LO and stray returns after completion are ignored.
        loads_before = loads;
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        step(0, 0, 1, 16'h1234);
        step(0, 0, 1, 16'h5678);
        step(0, 0, 1, 16'hFFFF);
        step(0, 0, 1, 16'hEEEE);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0);
        chk("noqueue_load_count", loads - loads_before, 1);
        chk("noqueue_pc", pc, 32'h1234_5678);

        // RTI with returns arriving early, during the pop cycles themselves.
        loads_before = loads;
        fl_before    = fl_loads;
        if (RtiEn) words.push_back(16'h000A);
        words.push_back(16'h0001);
        words.push_back(16'h2345);
        step(0, 1, 0, 16'h0);
        chk("rti_first_op", out, RtiEn ? POP_FLAGS_OP : POP_PC_HIGH_OP);
        foreach (words[i]) step(0, 0, 1, words[i]);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0);
        chk("rti_pc", pc, 32'h0001_2345);
        chk("rti_flags", flags, RtiEn ? 4'hA : 4'h0);
        chk("rti_load_count", loads - loads_before, 1);
        chk("rti_flags_load_count", fl_loads - fl_before, RtiEn ? 1 : 0);

        // Reset in WAIT after one return discards the partial PC.
        loads_before = loads;
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'h9999);
        pulse_reset();
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_stall", stall, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0);
        chk("midrst_no_load", loads - loads_before, 0);
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(0, 0, 1, 16'hAAAA);
        step(0, 0, 1, 16'hBBBB);
        step(0, 0, 0, 16'h0);
        chk("midrst_pc_after", pc, 32'hAAAA_BBBB);
        chk("midrst_load_after", loads - loads_before, 1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 2) == 0, 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
